kbd_option_ctrl: RTL and testbench

KBD_OPTION_CTRL -- requirements
Module: kbd_option_ctrl

---
 rtl/kbd_pkg.sv | 39 +++
 rtl/pulse_stretch.sv | 31 +++
 rtl/kbd_option_ctrl.sv | 127 ++++++++++++
 tb/tb_kbd_option_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared PS/2 set-2 scancode constants, decoder state encoding and action-key lookup
// for the keyboard option controller.
package kbd_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_SCROLL = 8'h7E;
  localparam logic [7:0] SC_F3     = 8'h04;
  localparam logic [7:0] SC_F2     = 8'h06;
  localparam logic [7:0] SC_F12    = 8'h07;

  // Indices into the held-key vector and the action vector
  localparam int KEY_SCROLL = 0;
  localparam int KEY_F3     = 1;
  localparam int KEY_F2     = 2;
  localparam int KEY_F12    = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } kbd_state_t;

  // Returns {hit, index}; hit=0 for bytes that are not action keys
  function automatic logic [2:0] key_lookup(input logic [7:0] sc);
    logic [2:0] r;
    r = 3'b000;
    case (sc)
      SC_SCROLL: r = {1'b1, 2'(KEY_SCROLL)};
      SC_F3:     r = {1'b1, 2'(KEY_F3)};
      SC_F2:     r = {1'b1, 2'(KEY_F2)};
      SC_F12:    r = {1'b1, 2'(KEY_F12)};
      default:   r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pulse_stretch.sv
// Retriggerable pulse stretcher: pulse is high for RESET_CYCLES cycles after the
// last trig; a new trig reloads the counter.
module pulse_stretch #(
  parameter int RESET_CYCLES = 1800
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic trig,
  output logic pulse
);

  localparam int CW = $clog2(RESET_CYCLES + 1);
  localparam logic [CW-1:0] LOAD = CW'(RESET_CYCLES);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] r_cnt;

  // Counts down to zero and stops there; never wraps
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (trig) begin
      r_cnt <= LOAD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - ONE;
    end
  end

  assign pulse = (r_cnt != '0);

endmodule

// File: rtl/kbd_option_ctrl.sv
// Keyboard option controller: decodes PS/2 set-2 bytes into video option toggles
// (scandoubler, scanlines, blend) and a stretched core reset pulse.
module kbd_option_ctrl
  import kbd_pkg::*;
#(
  parameter int RESET_CYCLES = 1800,
  parameter bit SD_INIT      = 1'b1
) (
  input  logic       clk_i,
  input  logic       res_n_i,
  input  logic       kbd_intr,
  input  logic [7:0] kbd_scancode,
  output logic       scandoubler_disable,
  output logic [1:0] scanlines,
  output logic       blend,
  output logic       core_reset,
  output kbd_state_t dbg_state
);

  // Handshake: kbd_intr is a single-cycle strobe qualifying kbd_scancode; there is
  // no backpressure, every strobed byte is consumed in the cycle it is presented.

  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  kbd_state_t r_state;
  kbd_state_t w_state_nxt;
  logic [3:0] r_held;
  logic [3:0] w_held_nxt;
  logic [3:0] w_act;
  logic [2:0] w_key;
  logic       w_key_hit;
  logic [1:0] w_key_idx;

  logic       r_sd;
  logic [1:0] r_scan;
  logic       r_blend;

  // Assert immediately, release after two clock edges
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n   = r_rst_sync[1];
  assign w_key     = key_lookup(kbd_scancode);
  assign w_key_hit = w_key[2];
  assign w_key_idx = w_key[1:0];

  always_ff @(posedge clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= ST_IDLE;
      r_held  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_held  <= w_held_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_held_nxt  = r_held;
    w_act       = '0;
    if (kbd_intr) begin
      case (r_state)
        ST_IDLE: begin
          if (kbd_scancode == SC_EXT) begin
            w_state_nxt = ST_EXT;
          end else if (kbd_scancode == SC_BRK) begin
            w_state_nxt = ST_BRK;
          end else if (w_key_hit) begin
            // A make while already held is typematic repeat
            if (!r_held[w_key_idx]) begin
              w_act[w_key_idx] = 1'b1;
            end
            w_held_nxt[w_key_idx] = 1'b1;
          end
        end
        ST_BRK: begin
          w_state_nxt = ST_IDLE;
          if (w_key_hit) begin
            w_held_nxt[w_key_idx] = 1'b0;
          end
        end
        ST_EXT: begin
          w_state_nxt = (kbd_scancode == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
        end
        ST_EXT_BRK: begin
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_sd    <= SD_INIT;
      r_scan  <= 2'd0;
      r_blend <= 1'b0;
    end else begin
      if (w_act[KEY_SCROLL]) r_sd    <= ~r_sd;
      if (w_act[KEY_F3])     r_scan  <= r_scan + 2'd1;
      if (w_act[KEY_F2])     r_blend <= ~r_blend;
    end
  end

  pulse_stretch #(
    .RESET_CYCLES(RESET_CYCLES)
  ) u_pulse_stretch (
    .clk_i (clk_i),
    .rst_n (w_rst_n),
    .trig  (w_act[KEY_F12]),
    .pulse (core_reset)
  );

  assign scandoubler_disable = r_sd;
  assign scanlines           = r_scan;
  assign blend               = r_blend;
  assign dbg_state           = r_state;

endmodule

// File: tb/tb_kbd_option_ctrl.sv
// Directed self-checking bench for kbd_option_ctrl: option toggles, typematic
// filtering, extended-code handling, reset pulse stretching and mid-sequence reset.
module tb_kbd_option_ctrl;
  import kbd_pkg::*;

  logic       clk_i;
  logic       res_n_i;
  logic       kbd_intr;
  logic [7:0] kbd_scancode;
  logic       scandoubler_disable;
  logic [1:0] scanlines;
  logic       blend;
  logic       core_reset;
  kbd_state_t dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  kbd_option_ctrl #(
    .RESET_CYCLES(1800),
    .SD_INIT(1'b1)
  ) dut (
    .clk_i               (clk_i),
    .res_n_i             (res_n_i),
    .kbd_intr            (kbd_intr),
    .kbd_scancode        (kbd_scancode),
    .scandoubler_disable (scandoubler_disable),
    .scanlines           (scanlines),
    .blend               (blend),
    .core_reset          (core_reset),
    .dbg_state           (dbg_state)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic apply_reset();
    @(posedge clk_i);
    #3;
    res_n_i = 1'b0;
    #1;
    n_checks++;
    if (scandoubler_disable !== 1'b1 || scanlines !== 2'd0 || blend !== 1'b0 ||
        core_reset !== 1'b0 || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL async_reset: got sd=%b scan=%0d blend=%b crst=%b st=%0d required 1 0 0 0 0",
               scandoubler_disable, scanlines, blend, core_reset, dbg_state);
    end
    repeat (3) @(posedge clk_i);
    #1;
    res_n_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
  endtask

  // driver: one strobed byte; returns 1 time unit after the edge that consumed it
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk_i);
    #1;
    kbd_intr     = 1'b1;
    kbd_scancode = b;
    @(posedge clk_i);
    #1;
    kbd_intr     = 1'b0;
    kbd_scancode = 8'h00;
  endtask

  task automatic test_reset();
    res_n_i      = 1'b0;
    kbd_intr     = 1'b0;
    kbd_scancode = 8'h00;
    repeat (4) @(posedge clk_i);
    @(negedge clk_i);
    n_checks++;
    if (scandoubler_disable !== 1'b1) begin
      n_fail++; $display("FAIL reset_sd: got %b required 1", scandoubler_disable);
    end
    n_checks++;
    if (scanlines !== 2'd0) begin
      n_fail++; $display("FAIL reset_scan: got %0d required 0", scanlines);
    end
    n_checks++;
    if (blend !== 1'b0 || core_reset !== 1'b0) begin
      n_fail++; $display("FAIL reset_blend_crst: got %b %b required 0 0", blend, core_reset);
    end
    n_checks++;
    if (dbg_state !== ST_IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d required %0d", dbg_state, ST_IDLE);
    end
    @(posedge clk_i);
    #1;
    res_n_i = 1'b1;
    // an F12 strobe on the first edge after release must be swallowed by the sync
    kbd_intr = 1'b1;
    kbd_scancode = SC_F12;
    @(posedge clk_i);
    #1;
    kbd_intr = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    n_checks++;
    if (core_reset !== 1'b0) begin
      n_fail++; $display("FAIL reset_sync_release: got crst=%b required 0", core_reset);
    end
  endtask

  task automatic test_scanlines();
    logic [1:0] exp_scan;
    exp_scan = 2'd0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i);
      #1;
      kbd_intr = 1'b1;
      kbd_scancode = SC_F3;
      @(negedge clk_i);
      n_checks++;
      if (scanlines !== exp_scan) begin
        n_fail++; $display("FAIL scan_before_%0d: got %0d required %0d", i, scanlines, exp_scan);
      end
      @(posedge clk_i);
      #1;
      kbd_intr = 1'b0;
      exp_scan = exp_scan + 2'd1;
      n_checks++;
      if (scanlines !== exp_scan) begin
        n_fail++; $display("FAIL scan_after_%0d: got %0d required %0d", i, scanlines, exp_scan);
      end
      send_byte(SC_BRK);
      send_byte(SC_F3);
    end
    n_checks++;
    if (scanlines !== 2'd0 || dbg_state !== ST_IDLE) begin
      n_fail++; $display("FAIL scan_wrap: got scan=%0d st=%0d required 0 0", scanlines, dbg_state);
    end
    // unknown byte in IDLE is ignored
    send_byte(8'h1C);
    n_checks++;
    if (dbg_state !== ST_IDLE || scanlines !== 2'd0 || blend !== 1'b0 || scandoubler_disable !== 1'b1) begin
      n_fail++; $display("FAIL unknown_byte: got st=%0d scan=%0d blend=%b sd=%b required 0 0 0 1",
                         dbg_state, scanlines, blend, scandoubler_disable);
    end
  endtask

  task automatic test_typematic();
    logic exp_sd [5];
    exp_sd = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      send_byte(SC_SCROLL);
      n_checks++;
      if (scandoubler_disable !== exp_sd[i]) begin
        n_fail++; $display("FAIL typematic_%0d: got sd=%b required %b", i, scandoubler_disable, exp_sd[i]);
      end
    end
    send_byte(SC_BRK);
    send_byte(SC_SCROLL);
    n_checks++;
    if (scandoubler_disable !== exp_sd[3]) begin
      n_fail++; $display("FAIL typematic_break: got sd=%b required %b", scandoubler_disable, exp_sd[3]);
    end
    send_byte(SC_SCROLL);
    n_checks++;
    if (scandoubler_disable !== exp_sd[4]) begin
      n_fail++; $display("FAIL typematic_remake: got sd=%b required %b", scandoubler_disable, exp_sd[4]);
    end
    send_byte(SC_BRK);
    send_byte(SC_SCROLL);
  endtask

  task automatic test_extended();
    send_byte(SC_EXT);
    n_checks++;
    if (dbg_state !== ST_EXT) begin
      n_fail++; $display("FAIL ext_state: got %0d required %0d", dbg_state, ST_EXT);
    end
    send_byte(SC_F2);
    send_byte(SC_EXT);
    send_byte(SC_BRK);
    n_checks++;
    if (dbg_state !== ST_EXT_BRK) begin
      n_fail++; $display("FAIL ext_brk_state: got %0d required %0d", dbg_state, ST_EXT_BRK);
    end
    send_byte(SC_F2);
    n_checks++;
    if (blend !== 1'b0 || dbg_state !== ST_IDLE) begin
      n_fail++; $display("FAIL ext_no_action: got blend=%b st=%0d required 0 0", blend, dbg_state);
    end
    // plain make, then an extended break must not release the held key
    send_byte(SC_F2);
    send_byte(SC_EXT);
    send_byte(SC_BRK);
    send_byte(SC_F2);
    send_byte(SC_F2);
    n_checks++;
    if (blend !== 1'b1) begin
      n_fail++; $display("FAIL ext_break_keeps_held: got blend=%b required 1", blend);
    end
    // F0 in EXT_BRK returns to IDLE with no action
    send_byte(SC_BRK);
    send_byte(SC_F2);
    send_byte(SC_EXT);
    send_byte(SC_BRK);
    send_byte(SC_BRK);
    n_checks++;
    if (dbg_state !== ST_IDLE) begin
      n_fail++; $display("FAIL ext_brk_f0: got st=%0d required 0", dbg_state);
    end
    send_byte(SC_F2);
    n_checks++;
    if (blend !== 1'b0) begin
      n_fail++; $display("FAIL blend_toggle_off: got blend=%b required 0", blend);
    end
    send_byte(SC_BRK);
    send_byte(SC_F2);
  endtask

  task automatic test_core_reset();
    int high_cnt;
    int first_low;
    high_cnt  = 0;
    first_low = 0;
    @(posedge clk_i);
    #1;
    kbd_intr = 1'b1;
    kbd_scancode = SC_F12;
    @(negedge clk_i);
    n_checks++;
    if (core_reset !== 1'b0) begin
      n_fail++; $display("FAIL crst_latency: got %b required 0", core_reset);
    end
    @(posedge clk_i);
    #1;
    kbd_intr = 1'b0;
    // k counts edges after the first F12 edge; the retrigger lands on edge 1000
    for (int k = 1; k <= 3000; k++) begin
      kbd_intr     = (k == 5 || k == 6 || k == 1000);
      kbd_scancode = (k == 5) ? SC_BRK : SC_F12;
      @(negedge clk_i);
      if (core_reset === 1'b1) begin
        high_cnt++;
      end else if (first_low == 0) begin
        first_low = k;
      end
      @(posedge clk_i);
      #1;
    end
    kbd_intr = 1'b0;
    n_checks++;
    if (high_cnt !== 2800) begin
      n_fail++; $display("FAIL crst_length: got %0d cycles required 2800", high_cnt);
    end
    n_checks++;
    if (first_low !== 2801) begin
      n_fail++; $display("FAIL crst_continuous: first low sample %0d required 2801", first_low);
    end
    n_checks++;
    if (blend !== 1'b0 || scandoubler_disable !== 1'b1 || scanlines !== 2'd0) begin
      n_fail++; $display("FAIL crst_options_kept: got blend=%b sd=%b scan=%0d required 0 1 0",
                         blend, scandoubler_disable, scanlines);
    end
    send_byte(SC_BRK);
    send_byte(SC_F12);
  endtask

  task automatic test_reset_mid_sequence();
    send_byte(SC_F3);
    send_byte(SC_SCROLL);
    send_byte(SC_BRK);
    repeat (3) @(posedge clk_i);
    #1;
    n_checks++;
    if (dbg_state !== ST_BRK || scanlines !== 2'd1 || scandoubler_disable !== 1'b0) begin
      n_fail++; $display("FAIL brk_hold: got st=%0d scan=%0d sd=%b required 1 1 0",
                         dbg_state, scanlines, scandoubler_disable);
    end
    apply_reset();
    send_byte(SC_F2);
    n_checks++;
    if (blend !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset_make: got blend=%b required 1", blend);
    end
    n_checks++;
    if (scandoubler_disable !== 1'b1 || scanlines !== 2'd0 || core_reset !== 1'b0 || dbg_state !== ST_IDLE) begin
      n_fail++; $display("FAIL mid_reset_others: got sd=%b scan=%0d crst=%b st=%0d required 1 0 0 0",
                         scandoubler_disable, scanlines, core_reset, dbg_state);
    end
    // held bit for F3 was cleared by reset, so this is a fresh make
    send_byte(SC_F3);
    n_checks++;
    if (scanlines !== 2'd1) begin
      n_fail++; $display("FAIL mid_reset_held_clear: got scan=%0d required 1", scanlines);
    end
  endtask

  task automatic test_double_break();
    apply_reset();
    send_byte(SC_BRK);
    send_byte(SC_BRK);
    n_checks++;
    if (dbg_state !== ST_IDLE) begin
      n_fail++; $display("FAIL double_break_state: got %0d required 0", dbg_state);
    end
    send_byte(SC_F3);
    n_checks++;
    if (scanlines !== 2'd1) begin
      n_fail++; $display("FAIL double_break_scan: got %0d required 1", scanlines);
    end
    send_byte(SC_BRK);
    send_byte(SC_EXT);
    n_checks++;
    if (dbg_state !== ST_IDLE || scanlines !== 2'd1) begin
      n_fail++; $display("FAIL brk_e0: got st=%0d scan=%0d required 0 1", dbg_state, scanlines);
    end
  endtask

  initial begin
    test_reset();
    test_scanlines();
    test_typematic();
    test_extended();
    test_core_reset();
    test_reset_mid_sequence();
    test_double_break();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
